// File: rtl/key_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : key_event_decoder
//  Function : Classifies a debounced key level into one-cycle press, release,
//             click, long-press and auto-repeat pulses plus a held level.
//  Revision : 1.0
// ============================================================================
module key_event_decoder #(
    parameter int          CW     = 20,
    parameter logic [CW-1:0] LONG_T = 20'd1000,
    parameter logic [CW-1:0] REP_T  = 20'd200,
    parameter logic        REP_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       press_p,
    output logic       release_p,
    output logic       click_p,
    output logic       long_p,
    output logic       rep_p,
    output logic       held,
    output logic [7:0] rep_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_long_last = LONG_T - 1'b1;
    localparam logic [CW-1:0] c_rep_last  = REP_T - 1'b1;

    state_t          r_state;
    state_t          w_state_n;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_n;
    logic            r_key_d;
    logic [7:0]      w_rep_cnt_n;
    logic            w_press_n;
    logic            w_release_n;
    logic            w_click_n;
    logic            w_long_n;
    logic            w_rep_n;
    logic            w_held_n;
    logic            w_rise;

    assign w_rise = key_in & ~r_key_d;

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_rep_cnt_n = rep_cnt;
        w_press_n   = 1'b0;
        w_release_n = 1'b0;
        w_click_n   = 1'b0;
        w_long_n    = 1'b0;
        w_rep_n     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_press_n   = 1'b1;
                    w_cnt_n     = '0;
                    w_rep_cnt_n = 8'd0;
                    w_state_n   = PRESS;
                end
            end
            PRESS: begin
                if (!key_in) begin
                    w_release_n = 1'b1;
                    w_click_n   = 1'b1;
                    w_state_n   = IDLE;
                end else if (r_cnt == c_long_last) begin
                    w_long_n  = 1'b1;
                    w_cnt_n   = '0;
                    w_state_n = HOLD;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (!key_in) begin
                    w_release_n = 1'b1;
                    w_state_n   = IDLE;
                end else if (REP_EN) begin
                    if (r_cnt == c_rep_last) begin
                        w_rep_n     = 1'b1;
                        w_cnt_n     = '0;
                        w_rep_cnt_n = (rep_cnt == 8'hFF) ? 8'hFF : rep_cnt + 8'd1;
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
        // Covers the release cycle too, where the next state is already IDLE.
        w_held_n = (w_state_n != IDLE) || (r_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_key_d   <= 1'b0;
            press_p   <= 1'b0;
            release_p <= 1'b0;
            click_p   <= 1'b0;
            long_p    <= 1'b0;
            rep_p     <= 1'b0;
            held      <= 1'b0;
            rep_cnt   <= 8'd0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_key_d   <= key_in;
            press_p   <= w_press_n;
            release_p <= w_release_n;
            click_p   <= w_click_n;
            long_p    <= w_long_n;
            rep_p     <= w_rep_n;
            held      <= w_held_n;
            rep_cnt   <= w_rep_cnt_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_event_decoder
//  Function : Scoreboard bench driving three decoder configurations with shared
//             directed and random key stimulus against a duration-based model.
//  Revision : 1.0
// ============================================================================
module tb_key_event_decoder;

    localparam int LT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_in = 1'b0;
    logic [2:0] press_p, release_p, click_p, long_p, rep_p, held;
    logic [7:0] rep_cnt [3];

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    always #5 clk = ~clk;

    key_event_decoder #(.CW(20), .LONG_T(20'd8), .REP_T(20'd4), .REP_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .key_in(key_in),
        .press_p(press_p[0]), .release_p(release_p[0]), .click_p(click_p[0]),
        .long_p(long_p[0]), .rep_p(rep_p[0]), .held(held[0]), .rep_cnt(rep_cnt[0]));

    key_event_decoder #(.CW(20), .LONG_T(20'd8), .REP_T(20'd4), .REP_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .key_in(key_in),
        .press_p(press_p[1]), .release_p(release_p[1]), .click_p(click_p[1]),
        .long_p(long_p[1]), .rep_p(rep_p[1]), .held(held[1]), .rep_cnt(rep_cnt[1]));

    key_event_decoder #(.CW(20), .LONG_T(20'd8), .REP_T(20'd1), .REP_EN(1'b1)) dut2 (
        .clk(clk), .rst(rst), .key_in(key_in),
        .press_p(press_p[2]), .release_p(release_p[2]), .click_p(click_p[2]),
        .long_p(long_p[2]), .rep_p(rep_p[2]), .held(held[2]), .rep_cnt(rep_cnt[2]));

    // Reference model: tracks how many edges have passed since the press edge.
    int  rep_t  [3] = '{4, 4, 1};
    bit  rep_en [3] = '{1'b1, 1'b0, 1'b1};
    bit  pressed[3] = '{1'b0, 1'b0, 1'b0};
    int  dur    [3] = '{0, 0, 0};
    int  reps   [3] = '{0, 0, 0};
    bit  prev_key = 1'b0;

    logic [41:0] sbq [$];

    task automatic model(input int c, input bit k, input bit r, output logic [13:0] e);
        bit p = 0, rl = 0, ck = 0, lg = 0, rp = 0, hd = 0;
        if (r) begin
            pressed[c] = 1'b0;
            reps[c]    = 0;
        end else if (!pressed[c]) begin
            if (k && !prev_key) begin
                p = 1; hd = 1;
                pressed[c] = 1'b1;
                dur[c]     = 0;
                reps[c]    = 0;
            end
        end else begin
            dur[c] = dur[c] + 1;
            hd = 1;
            if (!k) begin
                rl = 1;
                ck = (dur[c] <= LT);
                pressed[c] = 1'b0;
            end else if (dur[c] == LT) begin
                lg = 1;
            end else if (rep_en[c] && dur[c] > LT && ((dur[c] - LT) % rep_t[c]) == 0) begin
                rp = 1;
                if (reps[c] < 255) reps[c] = reps[c] + 1;
            end
        end
        e = {p, rl, ck, lg, rp, hd, 8'(reps[c])};
    endtask

    task automatic drive(input bit k, input bit r);
        logic [13:0] e0, e1, e2;
        @(negedge clk);
        key_in = k;
        rst    = r;
        model(0, k, r, e0);
        model(1, k, r, e1);
        model(2, k, r, e2);
        prev_key = r ? 1'b0 : k;
        sbq.push_back({e2, e1, e0});
    endtask

    task automatic hold(input int n);
        repeat (n) drive(1'b1, 1'b0);
    endtask

    task automatic gap(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    // Monitor: every cycle the DUTs present their registered outputs.
    always @(posedge clk) begin
        logic [41:0] e;
        logic [13:0] a;
        #1;
        cycle = cycle + 1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            for (int i = 0; i < 3; i++) begin
                a = {press_p[i], release_p[i], click_p[i], long_p[i], rep_p[i], held[i], rep_cnt[i]};
                checks = checks + 1;
                if (a !== e[i*14 +: 14]) begin
                    errors = errors + 1;
                    $display("FAIL outputs cfg%0d cycle %0d: got press/rel/click/long/rep/held=%b rep_cnt=%h, expected %b rep_cnt=%h",
                             i, cycle, a[13:8], a[7:0], e[i*14+8 +: 6], e[i*14 +: 8]);
                end
            end
        end
    end

    initial begin
        repeat (3) drive(1'b0, 1'b1);
        gap(2);
        // Short press, long press with repeats, release on terminal count.
        hold(3);  gap(3);
        hold(20); gap(3);
        hold(8);  gap(3);
        // Reset in the middle of HOLD while the key stays down.
        hold(10); drive(1'b1, 1'b1); hold(5); gap(3);
        // Saturating repeat count.
        hold(310); gap(3);
        // Key already high when reset deasserts.
        drive(1'b1, 1'b1); drive(1'b1, 1'b1); hold(5); gap(2);
        // Random traffic with occasional resets.
        repeat (60) begin
            if ($urandom_range(0, 19) == 0) drive(1'($urandom_range(0, 1)), 1'b1);
            hold($urandom_range(1, 30));
            gap($urandom_range(1, 5));
        end
        gap(2);
        @(posedge clk);
        #3;
        checks = checks + 1;
        if (sbq.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending, expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
